// File: rtl/i2c_pkg.sv
// Shared widths and FSM state encoding for the I2C target.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;

   // bit_cnt value once all 8 data bits of a byte have been clocked
   localparam logic [3:0] BIT_LAST = 4'd8;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } i2c_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchronizer for an asynchronous bus line, resetting to the idle-high level,
// with one-clk rise/fall pulses and the previous synced sample.
module i2c_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic din,
   output logic level,
   output logic prev,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] pipe;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pipe <= '1;
         prev <= 1'b1;
      end else begin
         pipe <= {pipe[STAGES-2:0], din};
         prev <= pipe[STAGES-1];
      end
   end

   assign level = pipe[STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: START/STOP detection, 7-bit address match, write bytes to rx_data, read bytes from tx_data.
//
//  state    | meaning
//  IDLE     | bus free or not yet seen a START
//  ADDR     | shifting in address + R/W bit
//  ADDR_ACK | driving ACK for a matched address
//  WR_DATA  | shifting in a write byte
//  WR_ACK   | driving ACK for a write byte
//  RD_DATA  | driving a read byte, MSB first
//  RD_ACK   | released, sampling the master's ACK/NACK
//  IGNORE   | not addressed or NACKed; wait for START/STOP
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLV_ADDR    = 7'h5A,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  scl,
   inout  wire                   sda,
   input  logic [I2C_BYTE_W-1:0] tx_data,
   output logic                  tx_req,
   output logic [I2C_BYTE_W-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  addr_hit
);

   logic scl_s, scl_prev, scl_rise, scl_fall;
   logic sda_s, sda_prev_unused, sda_rise, sda_fall;

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_scl (
      .clk   (clk),
      .rstn  (rstn),
      .din   (scl),
      .level (scl_s),
      .prev  (scl_prev),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sda (
      .clk   (clk),
      .rstn  (rstn),
      .din   (sda),
      .level (sda_s),
      .prev  (sda_prev_unused),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   // SCL must be stably high across both samples, so an SDA edge coincident with an SCL edge is ignored
   logic start_det, stop_det;
   assign start_det = sda_fall & scl_s & scl_prev;
   assign stop_det  = sda_rise & scl_s & scl_prev;

   i2c_state_t            state, state_n;
   logic [3:0]            bit_cnt, bit_cnt_n;
   logic [I2C_BYTE_W-1:0] shreg, shreg_n;
   logic [I2C_BYTE_W-1:0] rx_data_n;
   logic                  sda_oe, sda_oe_n;
   logic                  rx_valid_n, busy_n, addr_hit_n;

   assign sda = sda_oe ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         rx_data  <= '0;
         sda_oe   <= 1'b0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
         addr_hit <= 1'b0;
      end else begin
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         rx_data  <= rx_data_n;
         sda_oe   <= sda_oe_n;
         rx_valid <= rx_valid_n;
         busy     <= busy_n;
         addr_hit <= addr_hit_n;
      end
   end

   always_comb begin
      state_n    = state;
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      rx_data_n  = rx_data;
      sda_oe_n   = sda_oe;
      rx_valid_n = 1'b0;
      busy_n     = busy;
      addr_hit_n = addr_hit;
      tx_req     = 1'b0;

      if (start_det) begin
         state_n    = ADDR;
         bit_cnt_n  = '0;
         sda_oe_n   = 1'b0;
         busy_n     = 1'b1;
         addr_hit_n = 1'b0;
      end else if (stop_det) begin
         state_n    = IDLE;
         bit_cnt_n  = '0;
         sda_oe_n   = 1'b0;
         busy_n     = 1'b0;
         addr_hit_n = 1'b0;
      end else begin
         unique case (state)
            IDLE: ;

            ADDR: begin
               if (scl_rise && bit_cnt < BIT_LAST) begin
                  shreg_n   = {shreg[I2C_BYTE_W-2:0], sda_s};
                  bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == BIT_LAST) begin
                  bit_cnt_n = '0;
                  if (shreg[I2C_BYTE_W-1:1] == SLV_ADDR) begin
                     state_n    = ADDR_ACK;
                     sda_oe_n   = 1'b1;
                     addr_hit_n = 1'b1;
                  end else begin
                     state_n  = IGNORE;
                     sda_oe_n = 1'b0;
                  end
               end
            end

            ADDR_ACK: begin
               if (scl_fall) begin
                  if (shreg[0]) begin
                     tx_req   = 1'b1;
                     shreg_n  = tx_data;
                     sda_oe_n = ~tx_data[I2C_BYTE_W-1];
                     state_n  = RD_DATA;
                  end else begin
                     sda_oe_n = 1'b0;
                     state_n  = WR_DATA;
                  end
               end
            end

            WR_DATA: begin
               if (scl_rise && bit_cnt < BIT_LAST) begin
                  shreg_n   = {shreg[I2C_BYTE_W-2:0], sda_s};
                  bit_cnt_n = bit_cnt + 4'd1;
                  if (bit_cnt == BIT_LAST - 4'd1) begin
                     rx_data_n  = {shreg[I2C_BYTE_W-2:0], sda_s};
                     rx_valid_n = 1'b1;
                  end
               end else if (scl_fall && bit_cnt == BIT_LAST) begin
                  bit_cnt_n = '0;
                  sda_oe_n  = 1'b1;
                  state_n   = WR_ACK;
               end
            end

            WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_n = 1'b0;
                  state_n  = WR_DATA;
               end
            end

            RD_DATA: begin
               if (scl_rise && bit_cnt < BIT_LAST) begin
                  bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == BIT_LAST) begin
                  bit_cnt_n = '0;
                  sda_oe_n  = 1'b0;
                  state_n   = RD_ACK;
               end else if (scl_fall && bit_cnt != 4'd0) begin
                  sda_oe_n = ~shreg[I2C_BYTE_W-2];
                  shreg_n  = {shreg[I2C_BYTE_W-2:0], 1'b0};
               end
            end

            // a fall here can only follow an ACK rise; a NACK leaves on the rise itself
            RD_ACK: begin
               if (scl_rise && sda_s) begin
                  state_n = IGNORE;
               end else if (scl_fall) begin
                  tx_req   = 1'b1;
                  shreg_n  = tx_data;
                  sda_oe_n = ~tx_data[I2C_BYTE_W-1];
                  state_n  = RD_DATA;
               end
            end

            IGNORE: begin
               sda_oe_n = 1'b0;
            end

            default: begin
               state_n  = IDLE;
               sda_oe_n = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master driving i2c_slave; rx_valid/tx_req events are checked against a scoreboard.
module tb_i2c_slave;

   localparam int Q = 4;
   localparam int H = 8;

   logic       clk  = 1'b0;
   logic       rstn = 1'b0;
   logic       scl  = 1'b1;
   logic       m_oe = 1'b0;
   logic [7:0] tx_data = 8'h00;
   wire        sda;
   logic       tx_req, rx_valid, busy, addr_hit;
   logic [7:0] rx_data;

   pullup (sda);
   assign sda = m_oe ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_slave #(.SLV_ADDR(7'h5A), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .scl      (scl),
      .sda      (sda),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .addr_hit (addr_hit)
   );

   int         n_vec = 0;
   int         n_bad = 0;
   logic [7:0] rx_q[$];
   int         tx_q[$];

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor
   initial begin
      forever begin
         @(negedge clk);
         if (rx_valid === 1'b1) begin
            if (rx_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL rx_valid_unexpected: got rx_data %h, expected no rx_valid (t=%0t)", rx_data, $time);
            end else begin
               chk("rx_data_on_valid", rx_data, rx_q.pop_front());
            end
         end
         if (tx_req === 1'b1) begin
            n_vec++;
            if (tx_q.size() == 0) begin
               n_bad++;
               $display("FAIL tx_req_unexpected: got pulse, expected none (t=%0t)", $time);
            end else begin
               void'(tx_q.pop_front());
            end
         end
      end
   end

   task automatic clks(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_out(logic b);
      clks(Q); m_oe = ~b;
      clks(Q); scl = 1'b1;
      clks(H); scl = 1'b0;
   endtask

   task automatic send_bits(logic [7:0] b, int n);
      for (int i = 7; i > 7 - n; i--) bit_out(b[i]);
   endtask

   task automatic send_byte(logic [7:0] b, output logic ack);
      send_bits(b, 8);
      clks(Q); m_oe = 1'b0;
      clks(Q); scl = 1'b1;
      clks(H/2); ack = sda;
      clks(H/2); scl = 1'b0;
   endtask

   task automatic read_byte(output logic [7:0] b, input logic ack, input logic [7:0] next_tx);
      for (int i = 7; i >= 0; i--) begin
         clks(Q); m_oe = 1'b0;
         clks(Q); scl = 1'b1;
         clks(H/2); b[i] = sda;
         clks(H/2); scl = 1'b0;
      end
      tx_data = next_tx;
      clks(Q); m_oe = ~ack;
      clks(Q); scl = 1'b1;
      clks(H); scl = 1'b0;
   endtask

   task automatic do_start();
      clks(Q); m_oe = 1'b1;
      clks(Q); scl = 1'b0;
   endtask

   task automatic do_rstart();
      clks(Q); m_oe = 1'b0;
      clks(Q); scl = 1'b1;
      clks(Q); m_oe = 1'b1;
      clks(Q); scl = 1'b0;
   endtask

   task automatic do_stop();
      clks(Q); m_oe = 1'b1;
      clks(Q); scl = 1'b1;
      clks(Q); m_oe = 1'b0;
      clks(H);
   endtask

   task automatic test_write_3c();
      logic a;
      do_start();
      clks(1);
      chk("t1_busy_after_start", 8'(busy), 8'h01);
      send_byte(8'hB4, a);
      chk("t1_addr_ack", 8'(a), 8'h00);
      chk("t1_addr_hit", 8'(addr_hit), 8'h01);
      rx_q.push_back(8'h3C);
      send_byte(8'h3C, a);
      chk("t1_data_ack", 8'(a), 8'h00);
      do_stop();
      chk("t1_rx_data", rx_data, 8'h3C);
      chk("t1_busy_after_stop", 8'(busy), 8'h00);
      chk("t1_addr_hit_after_stop", 8'(addr_hit), 8'h00);
   endtask

   initial begin
      logic       a;
      logic [7:0] b;

      clks(3);
      chk("rst_busy", 8'(busy), 8'h00);
      chk("rst_addr_hit", 8'(addr_hit), 8'h00);
      chk("rst_rx_valid", 8'(rx_valid), 8'h00);
      chk("rst_tx_req", 8'(tx_req), 8'h00);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_sda", 8'(sda), 8'h01);
      rstn = 1'b1;
      clks(4);

      // 1: addressed write of 0x3C
      test_write_3c();
      clks(H);

      // 2: foreign address 0x5B, nothing driven or delivered
      do_start();
      send_byte(8'hB6, a);
      chk("t2_addr_nack", 8'(a), 8'h01);
      chk("t2_addr_hit", 8'(addr_hit), 8'h00);
      send_byte(8'hFF, a);
      chk("t2_data_nack", 8'(a), 8'h01);
      do_stop();
      chk("t2_busy", 8'(busy), 8'h00);
      clks(H);

      // 3: read A5 (ACK) then 0F (NACK)
      tx_data = 8'hA5;
      tx_q.push_back(1);
      tx_q.push_back(2);
      do_start();
      send_byte(8'hB5, a);
      chk("t3_addr_ack", 8'(a), 8'h00);
      chk("t3_addr_hit", 8'(addr_hit), 8'h01);
      read_byte(b, 1'b0, 8'h0F);
      chk("t3_rd_byte0", b, 8'hA5);
      read_byte(b, 1'b1, 8'h00);
      chk("t3_rd_byte1", b, 8'h0F);
      do_stop();
      chk("t3_busy", 8'(busy), 8'h00);
      clks(H);

      // 4: write 0x11, repeated START, read C3
      do_start();
      send_byte(8'hB4, a);
      chk("t4_addr_ack_w", 8'(a), 8'h00);
      rx_q.push_back(8'h11);
      send_byte(8'h11, a);
      chk("t4_data_ack", 8'(a), 8'h00);
      do_rstart();
      clks(1);
      chk("t4_busy_rstart", 8'(busy), 8'h01);
      tx_data = 8'hC3;
      tx_q.push_back(3);
      send_byte(8'hB5, a);
      chk("t4_addr_ack_r", 8'(a), 8'h00);
      chk("t4_addr_hit_r", 8'(addr_hit), 8'h01);
      read_byte(b, 1'b1, 8'h00);
      chk("t4_rd_byte", b, 8'hC3);
      do_stop();
      chk("t4_rx_data_held", rx_data, 8'h11);
      clks(H);

      // 5: reset during 4th bit of a write byte
      do_start();
      send_byte(8'hB4, a);
      chk("t5_addr_ack", 8'(a), 8'h00);
      send_bits(8'h96, 3);
      clks(Q); m_oe = 1'b1;
      clks(Q); scl = 1'b1;
      clks(Q); rstn = 1'b0;
      #1;
      chk("t5_sda_in_reset", 8'(sda), 8'h00);
      clks(2);
      chk("t5_busy", 8'(busy), 8'h00);
      chk("t5_addr_hit", 8'(addr_hit), 8'h00);
      chk("t5_rx_valid", 8'(rx_valid), 8'h00);
      chk("t5_rx_data", rx_data, 8'h00);
      m_oe = 1'b0;
      #1;
      chk("t5_sda_released", 8'(sda), 8'h01);
      rstn = 1'b1;
      clks(H);

      // 5b: reset while the target is driving the address ACK
      do_start();
      send_bits(8'hB4, 8);
      clks(Q); m_oe = 1'b0;
      clks(1);
      chk("t5b_sda_acking", 8'(sda), 8'h00);
      rstn = 1'b0;
      #1;
      chk("t5b_sda_async_release", 8'(sda), 8'h01);
      clks(2);
      rstn = 1'b1;
      scl = 1'b1;
      clks(H);
      chk("t5b_busy", 8'(busy), 8'h00);

      test_write_3c();
      clks(H);

      // 6: STOP injected on bit 5 of a data byte
      do_start();
      send_byte(8'hB4, a);
      chk("t6_addr_ack", 8'(a), 8'h00);
      send_bits(8'hE7, 4);
      do_stop();
      chk("t6_busy", 8'(busy), 8'h00);
      chk("t6_addr_hit", 8'(addr_hit), 8'h00);
      chk("t6_sda", 8'(sda), 8'h01);
      clks(H);

      chk("rx_events_missing", 8'(rx_q.size()), 8'h00);
      chk("tx_req_events_missing", 8'(tx_q.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
